// File: rtl/disp_pkg.sv
// Shared types and constants for the result display path: FSM states,
// display-symbol codes and their active-low seven-segment patterns.
package disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int SHIFT_CYCLES = 16;

   // Symbol codes 0-9 are the decimal digits themselves.
   localparam logic [3:0] SYM_BLANK = 4'd10;
   localparam logic [3:0] SYM_MINUS = 4'd11;
   localparam logic [3:0] SYM_O     = 4'd12;
   localparam logic [3:0] SYM_F     = 4'd13;

   // Active-low patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_F     = 7'b0001110;

endpackage

// File: rtl/seg7_decode.sv
// Combinational display-symbol to active-low seven-segment pattern decoder.
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] i_sym,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      unique case (i_sym)
         4'd0:      o_seg = SEG_0;
         4'd1:      o_seg = SEG_1;
         4'd2:      o_seg = SEG_2;
         4'd3:      o_seg = SEG_3;
         4'd4:      o_seg = SEG_4;
         4'd5:      o_seg = SEG_5;
         4'd6:      o_seg = SEG_6;
         4'd7:      o_seg = SEG_7;
         4'd8:      o_seg = SEG_8;
         4'd9:      o_seg = SEG_9;
         SYM_MINUS: o_seg = SEG_MINUS;
         SYM_O:     o_seg = SEG_O;
         SYM_F:     o_seg = SEG_F;
         default:   o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/result_display_driver.sv
// Converts a 16-bit arithmetic result to sign + 3 BCD digits (double-dabble)
// and scans it onto a 4-digit active-low seven-segment display.
// Build option: LEADING_ZERO_BLANK_EN blanks leading zeros of the magnitude.
//
// state    | meaning
// ST_IDLE  | waiting for load; display holds previous result
// ST_LOAD  | sign-magnitude split, BCD accumulator cleared
// ST_SHIFT | 16 add-3/shift iterations
// ST_DONE  | new digits visible, done pulse high
module result_display_driver
   import disp_pkg::*;
#(
   parameter logic [15:0] REFRESH_DIV = 16'd50000,
   parameter int          DATA_W      = 16
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] ans,
   input  logic              is_signed,
   input  logic              load,
   output logic              busy,
   output logic              done,
   output logic [6:0]        seg,
   output logic [3:0]        an,
   output logic              dp
);

   localparam logic [3:0] ITER_LAST = 4'(SHIFT_CYCLES - 1);

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_ans;
   logic              r_sgn;
   logic              r_neg;
   logic [DATA_W-1:0] r_mag;
   logic [19:0]       r_bcd;
   logic [3:0]        r_iter;
   logic [3:0][3:0]   r_disp;

   logic [15:0]       r_scan_cnt;
   logic [1:0]        r_idx;
   logic [3:0]        r_an;
   logic [6:0]        r_seg;

   logic [19:0]          w_adj;
   logic [20+DATA_W-1:0] w_shift;
   logic [19:0]          w_bcd_next;
   logic [DATA_W-1:0]    w_mag_next;
   logic                 w_ovf;
   logic [3:0][3:0]      w_new_disp;
   logic [6:0]           w_seg_sel;

   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < 5; k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5)
            w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
   end

   assign w_shift    = {w_adj, r_mag} << 1;
   assign w_bcd_next = w_shift[20+DATA_W-1:DATA_W];
   assign w_mag_next = w_shift[DATA_W-1:0];
   assign w_ovf      = |w_bcd_next[19:12];

   // Digits are formed from the post-shift value so they latch on the final shift edge.
   always_comb begin
      w_new_disp[3] = r_neg ? SYM_MINUS : SYM_BLANK;
      w_new_disp[2] = w_bcd_next[11:8];
      w_new_disp[1] = w_bcd_next[7:4];
      w_new_disp[0] = w_bcd_next[3:0];
      if (w_ovf) begin
         w_new_disp[2] = SYM_O;
         w_new_disp[1] = SYM_F;
         w_new_disp[0] = SYM_BLANK;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
         if (w_bcd_next[11:8] == 4'd0) begin
            w_new_disp[2] = SYM_BLANK;
            if (w_bcd_next[7:4] == 4'd0)
               w_new_disp[1] = SYM_BLANK;
         end
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ans   <= '0;
         r_sgn   <= 1'b0;
         r_neg   <= 1'b0;
         r_mag   <= '0;
         r_bcd   <= '0;
         r_iter  <= '0;
         r_disp  <= {4{SYM_BLANK}};
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_ans   <= ans;
                  r_sgn   <= is_signed;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_neg   <= r_sgn & r_ans[DATA_W-1];
               r_mag   <= (r_sgn & r_ans[DATA_W-1]) ? -r_ans : r_ans;
               r_bcd   <= '0;
               r_iter  <= '0;
               r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               r_bcd  <= w_bcd_next;
               r_mag  <= w_mag_next;
               r_iter <= r_iter + 4'd1;
               if (r_iter == ITER_LAST) begin
                  r_disp  <= w_new_disp;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   seg7_decode u_seg7_decode (
      .i_sym (r_disp[r_idx]),
      .o_seg (w_seg_sel)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
         r_an       <= 4'hF;
         r_seg      <= SEG_BLANK;
      end else begin
         if (r_scan_cnt == REFRESH_DIV - 16'd1) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
         end
         r_an  <= ~(4'b0001 << r_idx);
         r_seg <= w_seg_sel;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign seg  = r_seg;
   assign an   = r_an;
   assign dp   = 1'b1;

endmodule
